// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injection-port receiver: flit layout,
// flit type codes and receiver FSM states.
package noc_pkg;

  localparam int FLIT_W = 20;
  localparam int DEST_W = 4;

  // Flit field positions: [19:18] type, [17:14] dest, [13:0] payload
  localparam int TYPE_HI = 19;
  localparam int TYPE_LO = 18;
  localparam int DEST_HI = 17;
  localparam int DEST_LO = 14;

  typedef enum logic [1:0] {
    FT_SINGLE = 2'b00,
    FT_HEAD   = 2'b01,
    FT_BODY   = 2'b10,
    FT_TAIL   = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FWD  = 2'd2
  } rx_state_e;

  // A flit that opens a packet (needs a route)
  function automatic logic ft_is_head(input flit_type_e t);
    return (t == FT_SINGLE) || (t == FT_HEAD);
  endfunction

  // A flit that closes a packet (releases the route)
  function automatic logic ft_is_tail(input flit_type_e t);
    return (t == FT_SINGLE) || (t == FT_TAIL);
  endfunction

endpackage

// File: rtl/noc_rx_fifo.sv
// Synchronous flit FIFO with show-ahead front output. Push and pop in the
// same cycle are allowed even when full (the popped slot is the one written).
module noc_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_front,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks fill level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_front = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/noc_input_port_rx.sv
// Router-side receiver of the PE injection link: buffers flits, returns one
// credit per freed slot, requests a route for each packet head and forwards
// the packet to the crossbar under valid/ready.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no packet open; discard stray body/tail flits at the front
//   REQ     | head at front, route_req asserted until the allocator grants
//   FWD     | route held, stream flits out until the tail is accepted
module noc_input_port_rx #(
  parameter int DEPTH  = 8,
  parameter int FLIT_W = noc_pkg::FLIT_W,
  parameter int DEST_W = noc_pkg::DEST_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        flit_in,
  input  logic                     flit_in_valid,
  output logic                     credit_out,
  output logic                     route_req,
  output logic [DEST_W-1:0]        dest_out,
  input  logic                     route_grant,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     flit_out_valid,
  input  logic                     flit_out_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err,
  output logic                     framing_err
);

  import noc_pkg::*;

  rx_state_e          r_state;
  rx_state_e          w_state_nxt;
  logic               r_credit;
  logic               r_overflow;
  logic               r_framing;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_framing_set;
  logic [FLIT_W-1:0]  w_front;
  flit_type_e         w_front_type;

  // A full FIFO still accepts a flit when a slot frees in the same cycle
  assign w_push       = flit_in_valid && (!w_full || w_pop);
  assign w_front_type = flit_type_e'(w_front[TYPE_HI:TYPE_LO]);

  noc_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (FLIT_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (flit_in),
    .o_front (w_front),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  // Next-state, pop decision and combinational link outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_framing_set  = 1'b0;
    route_req      = 1'b0;
    dest_out       = '0;
    flit_out_valid = 1'b0;
    flit_out       = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (ft_is_head(w_front_type)) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_pop         = 1'b1;
            w_framing_set = 1'b1;
          end
        end
      end
      ST_REQ: begin
        route_req = 1'b1;
        dest_out  = w_front[DEST_LO +: DEST_W];
        if (route_grant) w_state_nxt = ST_FWD;
      end
      ST_FWD: begin
        if (!w_empty) begin
          flit_out_valid = 1'b1;
          flit_out       = w_front;
          if (flit_out_ready) begin
            w_pop = 1'b1;
            if (ft_is_tail(w_front_type)) w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, credit return and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
      r_framing  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_pop;
      r_overflow <= r_overflow | (flit_in_valid & w_full & ~w_pop);
      r_framing  <= r_framing | w_framing_set;
    end
  end

  assign credit_out   = r_credit;
  assign overflow_err = r_overflow;
  assign framing_err  = r_framing;

endmodule

// File: tb/tb_noc_input_port_rx.sv
// Self-checking bench for noc_input_port_rx: per-cycle vector table for the
// basic packet flows, hand sequences for overflow, framing, backpressure and
// mid-packet reset, and a scoreboard checking every forwarded flit in order.
module tb_noc_input_port_rx;

  logic        clk;
  logic        rst;
  logic [19:0] flit_in;
  logic        flit_in_valid;
  logic        credit_out;
  logic        route_req;
  logic [3:0]  dest_out;
  logic        route_grant;
  logic [19:0] flit_out;
  logic        flit_out_valid;
  logic        flit_out_ready;
  logic [3:0]  occupancy;
  logic        overflow_err;
  logic        framing_err;

  int          checks   = 0;
  int          failures = 0;
  logic [19:0] sb_q[$];
  logic [19:0] mon_exp;

  typedef struct {
    logic        vin;
    logic [19:0] fin;
    logic        gnt;
    logic        rdy;
    logic        sb;
    logic        e_req;
    logic [3:0]  e_dest;
    logic        e_val;
    logic [19:0] e_fout;
    logic        e_cred;
    logic [3:0]  e_occ;
  } vec_t;

  vec_t tv[17];

  noc_input_port_rx dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_in_valid  (flit_in_valid),
    .credit_out     (credit_out),
    .route_req      (route_req),
    .dest_out       (dest_out),
    .route_grant    (route_grant),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .flit_out_ready (flit_out_ready),
    .occupancy      (occupancy),
    .overflow_err   (overflow_err),
    .framing_err    (framing_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [1:0] t, input logic [3:0] d, input logic [13:0] p);
    return {t, d, p};
  endfunction

  function automatic vec_t mkv(input logic vin, input logic [19:0] fin, input logic gnt,
                               input logic rdy, input logic sb, input logic req,
                               input logic [3:0] dest, input logic val, input logic [19:0] fo,
                               input logic cred, input logic [3:0] occ);
    vec_t v;
    v.vin = vin; v.fin = fin; v.gnt = gnt; v.rdy = rdy; v.sb = sb;
    v.e_req = req; v.e_dest = dest; v.e_val = val; v.e_fout = fo;
    v.e_cred = cred; v.e_occ = occ;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_credit"}, 32'(credit_out), 32'd0);
    chk({tag, "_req"},    32'(route_req), 32'd0);
    chk({tag, "_dest"},   32'(dest_out), 32'd0);
    chk({tag, "_fout"},   32'(flit_out), 32'd0);
    chk({tag, "_valid"},  32'(flit_out_valid), 32'd0);
    chk({tag, "_occ"},    32'(occupancy), 32'd0);
    chk({tag, "_ovf"},    32'(overflow_err), 32'd0);
    chk({tag, "_frm"},    32'(framing_err), 32'd0);
  endtask

  task automatic do_reset();
    flit_in_valid  = 1'b0;
    flit_in        = '0;
    route_grant    = 1'b0;
    flit_out_ready = 1'b0;
    rst = 1'b0;
    sb_q.delete();
    step();
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  // Scoreboard: every beat accepted by the crossbar must be the next expected flit
  always @(negedge clk) begin
    if (rst && flit_out_valid && flit_out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got 0x%0h expected no beat", flit_out);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_flit", 32'(flit_out), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] s1, h2, b1, b2, b3, t2;
    logic [19:0] f3[9];
    logic [19:0] f5[4];
    logic        pre_v;
    logic [19:0] pre_f;
    logic        rdy;
    logic        got;
    logic        seen_req;
    logic [3:0]  seen_dest;

    s1 = 20'h0C123;
    h2 = mk(2'b01, 4'd5, 14'h0AA);
    b1 = mk(2'b10, 4'd5, 14'h001);
    b2 = mk(2'b10, 4'd5, 14'h002);
    b3 = mk(2'b10, 4'd5, 14'h003);
    t2 = mk(2'b11, 4'd5, 14'h004);

    //                vin   fin   gnt   rdy   sb    req   dest  val   fout  cred  occ
    tv[0]  = mkv(1'b1, s1,   1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, '0,   1'b0, 4'd1);
    tv[1]  = mkv(1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, '0,   1'b0, 4'd1);
    tv[2]  = mkv(1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, s1,   1'b0, 4'd1);
    tv[3]  = mkv(1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, '0,   1'b1, 4'd0);
    tv[4]  = mkv(1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, '0,   1'b0, 4'd0);
    tv[5]  = mkv(1'b1, h2,   1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, '0,   1'b0, 4'd1);
    tv[6]  = mkv(1'b1, b1,   1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, '0,   1'b0, 4'd2);
    tv[7]  = mkv(1'b1, b2,   1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, '0,   1'b0, 4'd3);
    tv[8]  = mkv(1'b1, b3,   1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, '0,   1'b0, 4'd4);
    tv[9]  = mkv(1'b1, t2,   1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, '0,   1'b0, 4'd5);
    tv[10] = mkv(1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, h2,   1'b0, 4'd5);
    tv[11] = mkv(1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, b1,   1'b1, 4'd4);
    tv[12] = mkv(1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, b2,   1'b1, 4'd3);
    tv[13] = mkv(1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, b3,   1'b1, 4'd2);
    tv[14] = mkv(1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, t2,   1'b1, 4'd1);
    tv[15] = mkv(1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, '0,   1'b1, 4'd0);
    tv[16] = mkv(1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, '0,   1'b0, 4'd0);

    // Reset state
    rst            = 1'b1;
    flit_in_valid  = 1'b0;
    flit_in        = '0;
    route_grant    = 1'b0;
    flit_out_ready = 1'b0;
    #2 rst = 1'b0;
    #2 chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // SINGLE packet, then HEAD+3 BODY+TAIL with late grant
    for (int i = 0; i < 17; i++) begin
      flit_in_valid  = tv[i].vin;
      flit_in        = tv[i].fin;
      route_grant    = tv[i].gnt;
      flit_out_ready = tv[i].rdy;
      if (tv[i].vin && tv[i].sb) sb_q.push_back(tv[i].fin);
      step();
      chk($sformatf("v%0d_req", i),   32'(route_req),      32'(tv[i].e_req));
      chk($sformatf("v%0d_dest", i),  32'(dest_out),       32'(tv[i].e_dest));
      chk($sformatf("v%0d_valid", i), 32'(flit_out_valid), 32'(tv[i].e_val));
      chk($sformatf("v%0d_fout", i),  32'(flit_out),       32'(tv[i].e_fout));
      chk($sformatf("v%0d_credit", i),32'(credit_out),     32'(tv[i].e_cred));
      chk($sformatf("v%0d_occ", i),   32'(occupancy),      32'(tv[i].e_occ));
    end
    flit_in_valid = 1'b0;
    route_grant   = 1'b0;

    // Overflow: fill 8, drop the 9th, then accept it alongside a pop
    flit_out_ready = 1'b0;
    f3[0] = mk(2'b01, 4'd2, 14'h100);
    for (int k = 1; k < 8; k++) f3[k] = mk(2'b10, 4'd2, 14'(14'h100 + k));
    f3[8] = mk(2'b11, 4'd2, 14'h1FF);
    for (int k = 0; k < 8; k++) begin
      flit_in_valid = 1'b1;
      flit_in       = f3[k];
      sb_q.push_back(f3[k]);
      step();
    end
    chk("ovf_full_occ", 32'(occupancy), 32'd8);
    chk("ovf_before", 32'(overflow_err), 32'd0);
    flit_in = f3[8];
    step();
    flit_in_valid = 1'b0;
    chk("ovf_drop_occ", 32'(occupancy), 32'd8);
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    step();
    step();
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
    chk("ovf_req", 32'(route_req), 32'd1);
    chk("ovf_dest", 32'(dest_out), 32'd2);
    route_grant = 1'b1;
    step();
    route_grant = 1'b0;
    chk("ovf_fwd_valid", 32'(flit_out_valid), 32'd1);
    chk("ovf_fwd_head", 32'(flit_out), 32'(f3[0]));
    step();
    chk("ovf_hold_head", 32'(flit_out), 32'(f3[0]));
    chk("ovf_hold_credit", 32'(credit_out), 32'd0);
    flit_out_ready = 1'b1;
    flit_in_valid  = 1'b1;
    flit_in        = f3[8];
    sb_q.push_back(f3[8]);
    step();
    flit_in_valid = 1'b0;
    chk("ovf_pushpop_occ", 32'(occupancy), 32'd8);
    chk("ovf_pushpop_credit", 32'(credit_out), 32'd1);
    for (int c = 0; c < 40; c++) begin
      if (occupancy == 4'd0 && !flit_out_valid) break;
      step();
    end
    chk("ovf_drain_occ", 32'(occupancy), 32'd0);
    chk("ovf_drain_valid", 32'(flit_out_valid), 32'd0);
    chk("ovf_drain_sb", 32'(sb_q.size()), 32'd0);
    chk("ovf_sticky_end", 32'(overflow_err), 32'd1);

    // Stray BODY flit in IDLE is discarded with a framing error and one credit
    do_reset();
    chk("frm_rst_ovf", 32'(overflow_err), 32'd0);
    chk("frm_rst_frm", 32'(framing_err), 32'd0);
    flit_in_valid = 1'b1;
    flit_in       = mk(2'b10, 4'd7, 14'h055);
    step();
    flit_in_valid = 1'b0;
    chk("frm_occ1", 32'(occupancy), 32'd1);
    chk("frm_req0", 32'(route_req), 32'd0);
    chk("frm_flag0", 32'(framing_err), 32'd0);
    step();
    chk("frm_occ0", 32'(occupancy), 32'd0);
    chk("frm_flag1", 32'(framing_err), 32'd1);
    chk("frm_credit", 32'(credit_out), 32'd1);
    chk("frm_req1", 32'(route_req), 32'd0);
    step();
    chk("frm_credit_end", 32'(credit_out), 32'd0);
    chk("frm_req2", 32'(route_req), 32'd0);
    chk("frm_sticky", 32'(framing_err), 32'd1);

    // Backpressure: ready toggles 1,0,1,0 during FWD
    do_reset();
    f5[0] = mk(2'b01, 4'd9, 14'h200);
    f5[1] = mk(2'b10, 4'd9, 14'h201);
    f5[2] = mk(2'b10, 4'd9, 14'h202);
    f5[3] = mk(2'b11, 4'd9, 14'h203);
    for (int k = 0; k < 4; k++) begin
      flit_in_valid = 1'b1;
      flit_in       = f5[k];
      sb_q.push_back(f5[k]);
      step();
    end
    flit_in_valid = 1'b0;
    chk("bp_req_dest", 32'(dest_out), 32'd9);
    route_grant = 1'b1;
    step();
    route_grant = 1'b0;
    for (int k = 0; k < 9; k++) begin
      pre_v = flit_out_valid;
      pre_f = flit_out;
      rdy   = (k % 2 == 0);
      flit_out_ready = rdy;
      step();
      if (pre_v && !rdy) chk($sformatf("bp_stable%0d", k), 32'(flit_out), 32'(pre_f));
      chk($sformatf("bp_credit%0d", k), 32'(credit_out), 32'(pre_v && rdy));
    end
    chk("bp_occ_end", 32'(occupancy), 32'd0);
    chk("bp_sb_end", 32'(sb_q.size()), 32'd0);

    // Reset mid-packet with 4 flits stored, then a fresh SINGLE packet
    do_reset();
    for (int k = 0; k < 4; k++) begin
      flit_in_valid = 1'b1;
      flit_in       = mk((k == 0) ? 2'b01 : 2'b10, 4'd1, 14'(14'h300 + k));
      step();
    end
    flit_in_valid = 1'b0;
    route_grant   = 1'b1;
    step();
    route_grant = 1'b0;
    chk("mrst_occ4", 32'(occupancy), 32'd4);
    chk("mrst_valid", 32'(flit_out_valid), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk_all_zero("mrst");
    step();
    @(negedge clk);
    rst = 1'b1;
    route_grant    = 1'b1;
    flit_out_ready = 1'b1;
    flit_in_valid  = 1'b1;
    flit_in        = mk(2'b00, 4'hA, 14'h123);
    sb_q.push_back(flit_in);
    step();
    flit_in_valid = 1'b0;
    got       = 1'b0;
    seen_req  = 1'b0;
    seen_dest = 4'd0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (route_req) begin
        seen_req  = 1'b1;
        seen_dest = dest_out;
      end
      if (credit_out) begin
        got = 1'b1;
        break;
      end
    end
    chk("post_req_seen", 32'(seen_req), 32'd1);
    chk("post_dest", 32'(seen_dest), 32'hA);
    chk("post_credit", 32'(got), 32'd1);
    step();
    chk("post_occ", 32'(occupancy), 32'd0);
    chk("post_valid", 32'(flit_out_valid), 32'd0);
    chk("post_credit_end", 32'(credit_out), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_input_port_rx.md
Name: noc_input_port_rx

Overview:
- Router-side receive end of the PE-to-router injection link: accepts 20-bit flits from a PE transmit buffer and stores them in a DEPTH-entry FIFO.
- Returns one credit pulse per freed slot on `credit_out`, which drives the PE's `ci` credit input.
- Decodes packet framing and issues a route request to the switch allocator. It forwards the packet's flits to the crossbar under a valid/ready handshake.

Parameters:
- DEPTH, 8: FIFO entries. Must be ≥ the sender's maximum outstanding flits (7). Power of two.
- FLIT_W, 20: flit width.
- DEST_W, 4: destination field width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flit_in  in  FLIT_W  flit from PE
- flit_in_valid  in  1  flit_in is valid this cycle
- credit_out  out  1  one-cycle pulse per dequeued or discarded flit (to PE `ci`)
- route_req  out  1  head flit waiting for switch allocation
- dest_out  out  DEST_W  destination of the head at the FIFO front
- route_grant  in  1  allocator grant; sampled only while route_req=1
- flit_out  out  FLIT_W  FIFO front flit to crossbar
- flit_out_valid  out  1  flit_out is valid
- flit_out_ready  in  1  crossbar accepts flit_out
- occupancy  out  $clog2(DEPTH)+1  current FIFO count
- overflow_err  out  1  sticky: flit arrived while FIFO full and not popping
- framing_err  out  1  sticky: body/tail flit at the FIFO front while in IDLE

Behaviour:
- Flit format:
  - [19:18] type: 00 SINGLE (head+tail), 01 HEAD, 10 BODY, 11 TAIL.
  - [17:14] dest.
  - [13:0] payload.
- Reset state (rst=0, asynchronous):
  - FIFO emptied, pointers and occupancy = 0.
  - FSM = IDLE.
  - credit_out, route_req, flit_out_valid, overflow_err, framing_err all 0.
  - dest_out and flit_out = 0.
  - Reset asserted mid-packet drops all stored flits. No credits are returned for dropped flits; the sender resets on the same rst.
- Write: on a clk edge with flit_in_valid=1:
  - Written if occupancy<DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop → write accepted, occupancy unchanged).
  - Otherwise the flit is dropped, overflow_err←1 and stays set until reset.
- Pop occurs when:
  - (a) FWD and flit_out_valid and flit_out_ready, or
  - (b) IDLE discard, described below.
- Occupancy: +1 on write only, −1 on pop only, unchanged on both.
- Pointers wrap modulo DEPTH.
- credit_out: registered. Equals 1 in the cycle after each pop, exactly one pulse per pop; back-to-back pops give back-to-back pulses.
- FSM, state IDLE:
  - FIFO non-empty with front type SINGLE or HEAD → REQ next cycle.
  - Front type BODY or TAIL → pop it (discard) this cycle, framing_err←1, remain IDLE.
  - Empty → stay.
- FSM, state REQ:
  - route_req=1 and dest_out=front[17:14], both combinational from state and front.
  - route_grant=1 → FWD next cycle; otherwise hold with route_req and dest_out stable.
- FSM, state FWD:
  - flit_out_valid = !empty; flit_out = front.
  - Pop of a flit with type SINGLE or TAIL → IDLE next cycle.
  - Empty mid-packet → wait in FWD with flit_out_valid=0.
  - flit_out must stay stable while valid and not ready.
- flit_out_valid=0 in IDLE and REQ.
- Latency:
  - Flit written at edge N → occupancy updated after N; route_req=1 after edge N+1.
  - Grant at edge M → flit_out_valid=1 after M.
  - Pop at edge P → credit_out=1 for the cycle after P.
- Throughput: one flit per cycle in FWD with ready held high.

Decomposition:
- Package `noc_pkg`: FLIT_W, DEST_W, flit type encodings (FT_SINGLE, FT_HEAD, FT_BODY, FT_TAIL), field bit positions, FSM state encoding.
- One sub-module `noc_rx_fifo`: synchronous FIFO with push, pop, full, empty, count and front output. FSM and credit logic stay in the top level.

Test Plan:
- Reset, then a SINGLE flit 0x0_C123 (dest 3), grant on first route_req, ready=1 → route_req=1 two cycles after injection with dest_out=3; flit_out=0x0C123 for one cycle; credit_out one pulse; FSM returns to IDLE.
- HEAD(dest 5) + 3 BODY + TAIL back-to-back, grant after 4 cycles, ready=1 → route_req held 4 cycles with dest_out=5; 5 consecutive flit_out beats in order; 5 consecutive credit pulses; occupancy returns to 0.
- Fill 8 flits with ready=0, send a 9th flit → occupancy=8, 9th dropped, overflow_err=1 and sticky; then 9th sent with a simultaneous pop → accepted, occupancy stays 8.
- BODY flit injected in IDLE → discarded, framing_err=1, one credit pulse, route_req never asserted.
- Packet mid-FWD with ready toggling 1,0,1,0 → flit_out stable while ready=0; credit pulses only after accepted beats.
- Reset asserted with 4 flits stored in FWD → all outputs 0 immediately; after release, a new SINGLE flit is processed normally.
